// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS sequencer: decodes opcode/funct into datapath enables and selects, one phase per clock.
// Latency: state advances every clk; outputs decode from the state register (plus mem_ready/zeroflag where noted).
// Backpressure: FETCH, MEMRD and MEMWR hold while mem_ready is low; fetch strobes wait for mem_ready.
module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zeroflag,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dest,
    output logic       memtoreg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [1:0] pc_src,
    output logic       instr_done,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t state_q;
    state_t state_d;
    logic   pc_write;
    logic   branch;
    logic   ir_write_raw;
    logic   mem_write_raw;
    logic   reg_write_raw;
    logic   instr_done_raw;

    // State register; reset aborts any instruction in flight and restarts at FETCH.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state sequencing; illegal encodings fall through to FETCH.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            default:  state_d = S_FETCH;
        endcase
    end

    // Per-state datapath controls; anything a state leaves alone stays 0 (ALU stays on add).
    always_comb begin
        iord           = 1'b0;
        mem_write_raw  = 1'b0;
        ir_write_raw   = 1'b0;
        reg_dest       = 1'b0;
        memtoreg       = 1'b0;
        reg_write_raw  = 1'b0;
        alu_src_a      = 1'b0;
        alu_src_b      = 2'b00;
        alu_control    = ALU_ADD;
        pc_src         = 2'b00;
        pc_write       = 1'b0;
        branch         = 1'b0;
        instr_done_raw = 1'b0;
        case (state_q)
            S_FETCH: begin
                alu_src_b    = 2'b01;
                ir_write_raw = mem_ready;
                pc_write     = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: instr_done_raw = 1'b0;
                    default: instr_done_raw = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                iord = 1'b1;
            end
            S_MEMWB: begin
                reg_write_raw  = 1'b1;
                memtoreg       = 1'b1;
                instr_done_raw = 1'b1;
            end
            S_MEMWR: begin
                iord           = 1'b1;
                mem_write_raw  = 1'b1;
                instr_done_raw = mem_ready;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                case (funct)
                    6'b100010: alu_control = ALU_SUB;
                    6'b100100: alu_control = ALU_AND;
                    6'b100101: alu_control = ALU_OR;
                    6'b101010: alu_control = ALU_SLT;
                    default:   alu_control = ALU_ADD;
                endcase
            end
            S_ALUWB: begin
                reg_write_raw  = 1'b1;
                reg_dest       = 1'b1;
                instr_done_raw = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a      = 1'b1;
                alu_control    = ALU_SUB;
                pc_src         = 2'b01;
                branch         = 1'b1;
                instr_done_raw = 1'b1;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_ADDIWB: begin
                reg_write_raw  = 1'b1;
                instr_done_raw = 1'b1;
            end
            S_JUMP: begin
                pc_src         = 2'b10;
                pc_write       = 1'b1;
                instr_done_raw = 1'b1;
            end
            default: begin
                alu_control = ALU_ADD;
            end
        endcase
    end

    // Architectural side effects are suppressed during the reset cycle.
    assign pc_en      = (pc_write | (branch & zeroflag)) & ~reset;
    assign ir_write   = ir_write_raw & ~reset;
    assign mem_write  = mem_write_raw & ~reset;
    assign reg_write  = reg_write_raw & ~reset;
    assign instr_done = instr_done_raw & ~reset;
    assign state      = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed per-cycle vector table plus random instruction stream.
// Inputs change on the falling edge; outputs are sampled 1ns later, well before the rising edge.
// Random instructions are checked against per-opcode phase lists with wait-state stretching.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zeroflag;
    logic       mem_ready;
    logic       pc_en, iord, mem_write, ir_write, reg_dest, memtoreg, reg_write, alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic [1:0] pc_src;
    logic       instr_done;
    logic [3:0] state;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .zeroflag(zeroflag), .mem_ready(mem_ready),
        .pc_en(pc_en), .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dest(reg_dest), .memtoreg(memtoreg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
        .pc_src(pc_src), .instr_done(instr_done), .state(state)
    );

    localparam logic [3:0] F = 4'd0, D = 4'd1, MA = 4'd2, MR = 4'd3, MWB = 4'd4, MW = 4'd5;
    localparam logic [3:0] EX = 4'd6, WB = 4'd7, BR = 4'd8, AE = 4'd9, AW = 4'd10, J = 4'd11;

    localparam logic [5:0] OPR = 6'b000000, OLW = 6'b100011, OSW = 6'b101011;
    localparam logic [5:0] OBEQ = 6'b000100, OADDI = 6'b001000, OJ = 6'b000010, OBAD = 6'b111111;

    localparam logic [2:0] ADD = 3'b010, SUB = 3'b110, SLT = 3'b111;

    int n_cmp = 0;
    int n_bad = 0;

    // strb bit order: {pc_en, ir_write, mem_write, reg_write, instr_done}
    typedef struct {
        logic       rst;
        logic [5:0] op;
        logic [5:0] fn;
        logic       zf;
        logic       mr;
        logic [3:0] st;
        logic [4:0] strb;
        logic [2:0] alu;
    } vec_t;

    typedef struct packed {
        logic       iord;
        logic       reg_dest;
        logic       memtoreg;
        logic       src_a;
        logic [1:0] src_b;
        logic [1:0] pc_src;
    } stat_t;

    vec_t  vq[$];
    stat_t stat_tab[16];

    task automatic add(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                       input logic zf, input logic mr, input logic [3:0] st,
                       input logic [4:0] strb, input logic [2:0] alu);
        vec_t v;
        v.rst = rst; v.op = op; v.fn = fn; v.zf = zf; v.mr = mr;
        v.st = st; v.strb = strb; v.alu = alu;
        vq.push_back(v);
    endtask

    task automatic apply(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                         input logic zf, input logic mr);
        @(negedge clk);
        reset = rst; opcode = op; funct = fn; zeroflag = zf; mem_ready = mr;
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] exp_st,
                         input logic [4:0] exp_strb, input logic [2:0] exp_alu);
        logic [11:0] got, exp;
        stat_t gs;
        got = {state, pc_en, ir_write, mem_write, reg_write, instr_done, alu_control};
        exp = {exp_st, exp_strb, exp_alu};
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got state=%0d strb=%b alu=%b, expected state=%0d strb=%b alu=%b",
                     name, state, got[7:3], alu_control, exp_st, exp_strb, exp_alu);
        end
        gs = {iord, reg_dest, memtoreg, alu_src_a, alu_src_b, pc_src};
        n_cmp++;
        if (gs !== stat_tab[exp_st]) begin
            n_bad++;
            $display("FAIL %s/selects in state %0d: got %b, expected %b", name, exp_st, gs, stat_tab[exp_st]);
        end
    endtask

    function automatic logic [2:0] alu_of(input logic [5:0] fn);
        case (fn)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    initial begin
        logic [3:0] path[$];
        logic [5:0] op, fn;
        logic       mr, zf, is_wait, adv, last, pc_e, ir_e, mw_e, rw_e, dn_e;
        logic [2:0] alu_e;
        int         i, cyc, dones, k;

        // {iord, reg_dest, memtoreg, src_a, src_b, pc_src} per state
        for (int s = 0; s < 16; s++) stat_tab[s] = '0;
        stat_tab[F]   = {1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00};
        stat_tab[D]   = {1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00};
        stat_tab[MA]  = {1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00};
        stat_tab[MR]  = {1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
        stat_tab[MWB] = {1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00};
        stat_tab[MW]  = {1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
        stat_tab[EX]  = {1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00};
        stat_tab[WB]  = {1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00};
        stat_tab[BR]  = {1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01};
        stat_tab[AE]  = {1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00};
        stat_tab[AW]  = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
        stat_tab[J]   = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10};

        // reset held 3 cycles with mem_ready=1, then lw with no waits
        for (int r = 0; r < 3; r++) add(1, OLW, 0, 0, 1, F, 5'b00000, ADD);
        add(0, OLW, 0, 0, 1, F,   5'b11000, ADD);
        add(0, OLW, 0, 0, 1, D,   5'b00000, ADD);
        add(0, OLW, 0, 0, 1, MA,  5'b00000, ADD);
        add(0, OLW, 0, 0, 1, MR,  5'b00000, ADD);
        add(0, OLW, 0, 0, 1, MWB, 5'b00011, ADD);
        // sw with two stalled MEMWR cycles
        add(0, OSW, 0, 0, 1, F,   5'b11000, ADD);
        add(0, OSW, 0, 0, 1, D,   5'b00000, ADD);
        add(0, OSW, 0, 0, 1, MA,  5'b00000, ADD);
        add(0, OSW, 0, 0, 0, MW,  5'b00100, ADD);
        add(0, OSW, 0, 0, 0, MW,  5'b00100, ADD);
        add(0, OSW, 0, 0, 1, MW,  5'b00101, ADD);
        // R-type: sub, slt, unknown funct
        add(0, OPR, 6'b100010, 0, 1, F,  5'b11000, ADD);
        add(0, OPR, 6'b100010, 0, 1, D,  5'b00000, ADD);
        add(0, OPR, 6'b100010, 0, 1, EX, 5'b00000, SUB);
        add(0, OPR, 6'b100010, 0, 1, WB, 5'b00011, ADD);
        add(0, OPR, 6'b101010, 0, 1, F,  5'b11000, ADD);
        add(0, OPR, 6'b101010, 0, 1, D,  5'b00000, ADD);
        add(0, OPR, 6'b101010, 0, 1, EX, 5'b00000, SLT);
        add(0, OPR, 6'b101010, 0, 1, WB, 5'b00011, ADD);
        add(0, OPR, 6'b111111, 0, 1, F,  5'b11000, ADD);
        add(0, OPR, 6'b111111, 0, 1, D,  5'b00000, ADD);
        add(0, OPR, 6'b111111, 0, 1, EX, 5'b00000, ADD);
        add(0, OPR, 6'b111111, 0, 1, WB, 5'b00011, ADD);
        // beq taken then not taken; zeroflag must not leak into pc_en outside BRANCH
        add(0, OBEQ, 0, 1, 1, F,  5'b11000, ADD);
        add(0, OBEQ, 0, 1, 1, D,  5'b00000, ADD);
        add(0, OBEQ, 0, 1, 1, BR, 5'b10001, SUB);
        add(0, OBEQ, 0, 0, 1, F,  5'b11000, ADD);
        add(0, OBEQ, 0, 0, 1, D,  5'b00000, ADD);
        add(0, OBEQ, 0, 0, 1, BR, 5'b00001, SUB);
        // j, then unsupported opcode, then a stalled fetch, then addi
        add(0, OJ,    0, 0, 1, F,  5'b11000, ADD);
        add(0, OJ,    0, 0, 1, D,  5'b00000, ADD);
        add(0, OJ,    0, 0, 1, J,  5'b10001, ADD);
        add(0, OBAD,  0, 0, 1, F,  5'b11000, ADD);
        add(0, OBAD,  0, 0, 1, D,  5'b00001, ADD);
        add(0, OADDI, 0, 0, 0, F,  5'b00000, ADD);
        add(0, OADDI, 0, 0, 1, F,  5'b11000, ADD);
        add(0, OADDI, 0, 0, 1, D,  5'b00000, ADD);
        add(0, OADDI, 0, 0, 1, AE, 5'b00000, ADD);
        add(0, OADDI, 0, 0, 1, AW, 5'b00011, ADD);
        // lw aborted by reset in MEMRD: no strobes, restart at FETCH
        add(0, OLW, 0, 0, 1, F,  5'b11000, ADD);
        add(0, OLW, 0, 0, 1, D,  5'b00000, ADD);
        add(0, OLW, 0, 0, 1, MA, 5'b00000, ADD);
        add(1, OLW, 0, 0, 1, MR, 5'b00000, ADD);
        add(0, OLW, 0, 0, 1, F,  5'b11000, ADD);

        reset = 1'b1; opcode = OLW; funct = '0; zeroflag = 1'b0; mem_ready = 1'b1;
        @(posedge clk);

        foreach (vq[n]) begin
            apply(vq[n].rst, vq[n].op, vq[n].fn, vq[n].zf, vq[n].mr);
            check($sformatf("vec%0d", n), vq[n].st, vq[n].strb, vq[n].alu);
        end

        // clean start for the random stream
        apply(1, OLW, 0, 0, 1);

        for (int t = 0; t < 300; t++) begin
            k = $urandom_range(0, 6);
            case (k)
                0: op = OLW;
                1: op = OSW;
                2: op = OPR;
                3: op = OADDI;
                4: op = OBEQ;
                5: op = OJ;
                default: op = ($urandom_range(0, 1) == 0) ? OBAD : 6'b001101;
            endcase
            k = $urandom_range(0, 5);
            case (k)
                0: fn = 6'b100000;
                1: fn = 6'b100010;
                2: fn = 6'b100100;
                3: fn = 6'b100101;
                4: fn = 6'b101010;
                default: fn = 6'($urandom);
            endcase
            path = {F, D};
            case (op)
                OLW:   path = {path, MA, MR, MWB};
                OSW:   path = {path, MA, MW};
                OPR:   path = {path, EX, WB};
                OADDI: path = {path, AE, AW};
                OBEQ:  path = {path, BR};
                OJ:    path = {path, J};
                default: ;
            endcase
            i = 0; cyc = 0; dones = 0;
            while (i < path.size() && cyc < 64) begin
                mr = ($urandom_range(0, 3) != 0);
                zf = 1'($urandom_range(0, 1));
                apply(0, op, fn, zf, mr);
                is_wait = (path[i] == F) || (path[i] == MR) || (path[i] == MW);
                adv     = !is_wait || mr;
                last    = (i == path.size() - 1);
                pc_e    = (path[i] == F && mr) || (path[i] == J) || (path[i] == BR && zf);
                ir_e    = (path[i] == F) && mr;
                mw_e    = (path[i] == MW);
                rw_e    = (path[i] == MWB) || (path[i] == WB) || (path[i] == AW);
                dn_e    = last && adv;
                alu_e   = (path[i] == EX) ? alu_of(fn) : (path[i] == BR) ? SUB : ADD;
                check($sformatf("rand%0d op=%b", t, op), path[i], {pc_e, ir_e, mw_e, rw_e, dn_e}, alu_e);
                if (instr_done) dones++;
                if (adv) i++;
                cyc++;
            end
            n_cmp++;
            if (i < path.size()) begin
                n_bad++;
                $display("FAIL rand%0d timeout: reached phase %0d of %0d after %0d cycles", t, i, path.size(), cyc);
            end
            n_cmp++;
            if (dones != 1) begin
                n_bad++;
                $display("FAIL rand%0d done_count: got %0d pulses, expected 1", t, dones);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Sequencing controller for the multi-cycle variant of the 32-bit MIPS core. It decodes the latched instruction opcode/funct and drives every datapath enable and mux select one step per clock, so a single ALU and a single unified memory are shared across instruction phases. It handles a simple memory-ready handshake and sits between the instruction register and the multi-cycle datapath.

## Interface
- No parameters; all widths are fixed by the ISA subset.
- clk  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  6  instr[31:26] from the instruction register; valid from DECODE onward.
- funct  in  6  instr[5:0] from the instruction register.
- zeroflag  in  1  ALU zero flag, combinational in the current cycle.
- mem_ready  in  1  memory completed the current access this cycle.
- pc_en  out  1  PC load enable, equal to pc_write | (branch & zeroflag).
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  instruction register load.
- reg_dest  out  1  write register select: 0 = rt, 1 = rd.
- memtoreg  out  1  register write data select: 0 = ALUOut, 1 = memory data register.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = register A.
- alu_src_b  out  2  ALU B select: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left by 2.
- alu_control  out  3  ALU operation: 010 = add, 110 = sub, 000 = and, 001 = or, 111 = slt.
- pc_src  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- instr_done  out  1  one-cycle pulse in the final state of each instruction.
- state  out  4  current state, for debug and verification.

## Operation
- Supported opcodes:
  - R-type 000000
  - lw 100011
  - sw 101011
  - beq 000100
  - addi 001000
  - j 000010
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11. Encodings 12–15 are illegal and go to FETCH on the next edge.
- FETCH: iord=0, alu_src_a=0, alu_src_b=01, add.
  - If mem_ready=1: ir_write=1 and pc_write=1 (pc_src=00), then go to DECODE.
  - Otherwise: both strobes are 0 and the controller stays in FETCH.
- DECODE: alu_src_a=0, alu_src_b=11, add (precomputes the branch target).
  - Next state by opcode: lw/sw → MEMADR, R → EXEC, beq → BRANCH, addi → ADDIEX, j → JUMP.
  - Any unsupported opcode → FETCH, with instr_done=1 (treated as a NOP).
- MEMADR: alu_src_a=1, alu_src_b=10, add. Next state is MEMRD for lw, MEMWR for sw.
- MEMRD: iord=1. Stays in MEMRD until mem_ready=1, then goes to MEMWB.
- MEMWB: reg_write=1, reg_dest=0, memtoreg=1, instr_done=1, then FETCH.
- MEMWR: iord=1, mem_write=1 for every cycle spent in the state. Stays until mem_ready=1; that cycle sets instr_done=1, then FETCH.
- EXEC: alu_src_a=1, alu_src_b=00. alu_control comes from funct:
  - 100000 → 010
  - 100010 → 110
  - 100100 → 000
  - 100101 → 001
  - 101010 → 111
  - any other funct → 010
- ALUWB: reg_write=1, reg_dest=1, memtoreg=0, instr_done=1, then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, sub, pc_src=01, branch=1, instr_done=1, then FETCH. pc_en follows zeroflag in that same cycle.
- ADDIEX: alu_src_a=1, alu_src_b=10, add, then ADDIWB.
- ADDIWB: reg_write=1, reg_dest=0, memtoreg=0, instr_done=1, then FETCH.
- JUMP: pc_src=10, pc_write=1, instr_done=1, then FETCH.
- Defaults: every output a state does not drive is 0, except alu_control, which defaults to 010.

## Timing
- Outputs are decoded from the state register. pc_en, and the FETCH, MEMRD and MEMWR strobes, additionally depend combinationally on zeroflag or mem_ready.
- Reset behaviour:
  - On a clock edge with reset=1, state becomes FETCH.
  - While reset=1, pc_en, ir_write, mem_write, reg_write and instr_done are forced to 0, regardless of mem_ready.
  - After reset, state=0 and all outputs are 0 except alu_src_b=01 and alu_control=010.
- Cycle counts with mem_ready held at 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, unsupported opcode 2.
- Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
- Reset asserted mid-instruction aborts it: no write strobes are issued in the reset cycle and the next state is FETCH.
- instr_done is high for exactly one cycle per instruction.

## Test plan
- Reset held for 3 cycles with mem_ready=1 → state=0, and pc_en, ir_write, mem_write and reg_write stay 0 throughout. In the first cycle after reset, ir_write=1 and pc_en=1.
- lw (opcode 100011) with mem_ready held at 1 → state sequence 0,1,2,3,4,0; reg_write=1 and memtoreg=1 only in state 4; instr_done pulses once.
- sw with mem_ready=0 for 2 cycles in MEMWR → mem_write=1 for 3 cycles and instr_done=1 on the third; reg_write is never asserted.
- R-type with funct 100010, then 101010, then 111111 → alu_control in EXEC is 110, then 111, then 010; ALUWB asserts reg_dest=1 and reg_write=1.
- beq with zeroflag=1, then a second beq with zeroflag=0 → in BRANCH, pc_en=1 and pc_src=01 for the first; pc_en=0 for the second. Both take 3 cycles.
- j, then opcode 111111 → j follows 0,1,11,0 with pc_src=10 and pc_en=1 in JUMP. The unsupported opcode follows 0,1,0 with instr_done=1 in DECODE and no write strobes.
